// File: rtl/bomb_fuse_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bomb_fuse_engine
// Description : Bomb manager between the character controller and the
//               display/score stages. Accepts bomb placements, runs per-slot
//               fuse/blast timers on a 1 Hz tick, applies blast damage to
//               both players, derives the game state and answers registered
//               per-cell bomb/blast queries for the renderer.
// Ports       : clk, reset_sw (async, active-high)
//               i_tick_1hz                  1 Hz one-clk pulse
//               i_place_req/_owner/_x/_y    placement request
//               i_pa_x/_y, i_pb_x/_y        player cells
//               i_query_x/_y                renderer query cell
//               o_place_ack/_nack           placement result pulse
//               o_q_bomb/o_q_blast          query result (1-cycle latency)
//               o_health_a/_b, o_hit_a/_b   health values and loss pulses
//               o_game_state                0 play, 1 A wins, 2 B wins, 3 draw
// Config      : CHAIN_REACTION_EN - armed bombs inside an existing blast
//               detonate on the next tick regardless of their fuse count.
// Revision    : 1.0 - initial release
// ============================================================================
module bomb_fuse_engine #(
    parameter int MAX_BOMBS    = 4,
    parameter int FUSE_TICKS   = 3,
    parameter int BLAST_TICKS  = 1,
    parameter int BLAST_RADIUS = 2
) (
    input  logic       clk,
    input  logic       reset_sw,
    input  logic       i_tick_1hz,
    input  logic       i_place_req,
    input  logic       i_place_owner,
    input  logic [3:0] i_place_x,
    input  logic [3:0] i_place_y,
    input  logic [3:0] i_pa_x,
    input  logic [3:0] i_pa_y,
    input  logic [3:0] i_pb_x,
    input  logic [3:0] i_pb_y,
    input  logic [3:0] i_query_x,
    input  logic [3:0] i_query_y,
    output logic       o_place_ack,
    output logic       o_place_nack,
    output logic       o_q_bomb,
    output logic       o_q_blast,
    output logic [1:0] o_health_a,
    output logic [1:0] o_health_b,
    output logic       o_hit_a,
    output logic       o_hit_b,
    output logic [1:0] o_game_state
);

    localparam int         c_IDX_W    = (MAX_BOMBS > 1) ? $clog2(MAX_BOMBS) : 1;
    localparam logic [2:0] c_FUSE     = 3'(FUSE_TICKS);
    localparam logic [2:0] c_BLAST    = 3'(BLAST_TICKS);
    localparam logic [4:0] c_RADIUS   = 5'(BLAST_RADIUS);
    localparam logic [3:0] c_CELL_MAX = 4'd9;
    localparam logic [3:0] c_PLACE_LO = 4'd1;
    localparam logic [3:0] c_PLACE_HI = 4'd8;

    typedef enum logic [1:0] {
        S_FREE  = 2'd0,
        S_ARMED = 2'd1,
        S_BLAST = 2'd2
    } slot_state_t;

    // Slot records
    slot_state_t          r_state [MAX_BOMBS];
    logic [2:0]           r_cnt   [MAX_BOMBS];
    logic [3:0]           r_x     [MAX_BOMBS];
    logic [3:0]           r_y     [MAX_BOMBS];
    logic [MAX_BOMBS-1:0] r_owner;

    // Control / output registers
    logic       r_ack, r_nack, r_tick_d1;
    logic [1:0] r_health_a, r_health_b, r_game_state;
    logic       r_hit_a, r_hit_b, r_q_bomb, r_q_blast;

    // Combinational
    slot_state_t          w_state_nxt [MAX_BOMBS];
    logic [2:0]           w_cnt_nxt   [MAX_BOMBS];
    logic [MAX_BOMBS-1:0] w_chain;
    logic [c_IDX_W-1:0]   w_free_idx;
    logic                 w_free_found, w_dup, w_coord_ok, w_accept;
    logic                 w_playing, w_tick;
    logic                 w_in_a, w_in_b, w_dmg_a, w_dmg_b;
    logic [1:0]           w_health_a_nxt, w_health_b_nxt;
    logic                 w_q_bomb, w_q_blast;
    logic                 w_unused_owner;

    // Cross-shaped blast membership. Cells beyond 9 do not exist, so they
    // are never inside a blast even if the arithmetic would reach them.
    function automatic logic f_in_blast(input logic [3:0] sx, input logic [3:0] sy,
                                        input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx;
        logic [3:0] dy;
        dx = (cx >= sx) ? (cx - sx) : (sx - cx);
        dy = (cy >= sy) ? (cy - sy) : (sy - cy);
        return (cx <= c_CELL_MAX) && (cy <= c_CELL_MAX) &&
               (((cy == sy) && ({1'b0, dx} <= c_RADIUS)) ||
                ((cx == sx) && ({1'b0, dy} <= c_RADIUS)));
    endfunction

    assign w_playing = (r_game_state == 2'd0);
    // A finished game freezes every slot.
    assign w_tick    = i_tick_1hz & w_playing;

    // Placement decision against the registered slot table; a slot that is
    // freed by a coincident tick only becomes available on the next request.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_dup        = 1'b0;
        for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
            if (r_state[i] == S_FREE) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end else if ((r_x[i] == i_place_x) && (r_y[i] == i_place_y)) begin
                w_dup = 1'b1;
            end
        end
        w_coord_ok = (i_place_x >= c_PLACE_LO) && (i_place_x <= c_PLACE_HI) &&
                     (i_place_y >= c_PLACE_LO) && (i_place_y <= c_PLACE_HI);
        w_accept   = i_place_req & w_playing & w_free_found & ~w_dup & w_coord_ok;
    end

`ifdef CHAIN_REACTION_EN
    // Only slots already in BLAST before this tick can ignite a neighbour,
    // so a chain advances one hop per tick.
    always_comb begin
        w_chain = '0;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            for (int j = 0; j < MAX_BOMBS; j++) begin
                if ((r_state[j] == S_BLAST) &&
                    f_in_blast(r_x[j], r_y[j], r_x[i], r_y[i])) begin
                    w_chain[i] = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        w_chain = '0;
    end
`endif

    // Per-slot FSM next state
    always_comb begin
        for (int i = 0; i < MAX_BOMBS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            if (w_tick) begin
                case (r_state[i])
                    S_ARMED: begin
                        if (w_chain[i] || (r_cnt[i] <= 3'd1)) begin
                            w_state_nxt[i] = S_BLAST;
                            w_cnt_nxt[i]   = c_BLAST;
                        end else begin
                            w_cnt_nxt[i]   = r_cnt[i] - 3'd1;
                        end
                    end
                    S_BLAST: begin
                        if (r_cnt[i] <= 3'd1) begin
                            w_state_nxt[i] = S_FREE;
                            w_cnt_nxt[i]   = 3'd0;
                        end else begin
                            w_cnt_nxt[i]   = r_cnt[i] - 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
            // The chosen slot is FREE, so the tick above never touched it.
            if (w_accept && (w_free_idx == c_IDX_W'(i))) begin
                w_state_nxt[i] = S_ARMED;
                w_cnt_nxt[i]   = c_FUSE;
            end
        end
    end

    // Damage and query evaluation from the registered slot table
    always_comb begin
        w_in_a    = 1'b0;
        w_in_b    = 1'b0;
        w_q_bomb  = 1'b0;
        w_q_blast = 1'b0;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            if (r_state[i] == S_BLAST) begin
                if (f_in_blast(r_x[i], r_y[i], i_pa_x, i_pa_y))       w_in_a    = 1'b1;
                if (f_in_blast(r_x[i], r_y[i], i_pb_x, i_pb_y))       w_in_b    = 1'b1;
                if (f_in_blast(r_x[i], r_y[i], i_query_x, i_query_y)) w_q_blast = 1'b1;
            end
            if ((r_state[i] == S_ARMED) && (r_x[i] == i_query_x) && (r_y[i] == i_query_y)) begin
                w_q_bomb = 1'b1;
            end
        end
        // Overlapping blasts still cost only one point per tick.
        w_dmg_a        = r_tick_d1 & w_playing & w_in_a & (r_health_a != 2'd0);
        w_dmg_b        = r_tick_d1 & w_playing & w_in_b & (r_health_b != 2'd0);
        w_health_a_nxt = r_health_a - {1'b0, w_dmg_a};
        w_health_b_nxt = r_health_b - {1'b0, w_dmg_b};
    end

    // Owner is kept per slot for downstream scoring; nothing here consumes it.
    assign w_unused_owner = ^r_owner;

    always_ff @(posedge clk or posedge reset_sw) begin
        if (reset_sw) begin
            for (int i = 0; i < MAX_BOMBS; i++) begin
                r_state[i] <= S_FREE;
                r_cnt[i]   <= 3'd0;
                r_x[i]     <= 4'd0;
                r_y[i]     <= 4'd0;
            end
            r_owner <= '0;
        end else begin
            for (int i = 0; i < MAX_BOMBS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            if (w_accept) begin
                r_x[w_free_idx]     <= i_place_x;
                r_y[w_free_idx]     <= i_place_y;
                r_owner[w_free_idx] <= i_place_owner;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_sw) begin
        if (reset_sw) begin
            r_ack        <= 1'b0;
            r_nack       <= 1'b0;
            r_tick_d1    <= 1'b0;
            r_health_a   <= 2'd3;
            r_health_b   <= 2'd3;
            r_hit_a      <= 1'b0;
            r_hit_b      <= 1'b0;
            r_game_state <= 2'd0;
            r_q_bomb     <= 1'b0;
            r_q_blast    <= 1'b0;
        end else begin
            r_ack      <= w_accept;
            r_nack     <= i_place_req & ~w_accept;
            // Damage edge is one cycle after the tick so it sees post-tick slots.
            r_tick_d1  <= w_tick;
            r_health_a <= w_health_a_nxt;
            r_health_b <= w_health_b_nxt;
            r_hit_a    <= w_dmg_a;
            r_hit_b    <= w_dmg_b;
            r_q_bomb   <= w_q_bomb;
            r_q_blast  <= w_q_blast;
            if (r_tick_d1 && w_playing) begin
                case ({(w_health_a_nxt == 2'd0), (w_health_b_nxt == 2'd0)})
                    2'b11:   r_game_state <= 2'd3;
                    2'b01:   r_game_state <= 2'd1;
                    2'b10:   r_game_state <= 2'd2;
                    default: r_game_state <= 2'd0;
                endcase
            end
        end
    end

    assign o_place_ack  = r_ack;
    assign o_place_nack = r_nack;
    assign o_q_bomb     = r_q_bomb;
    assign o_q_blast    = r_q_blast;
    assign o_health_a   = r_health_a;
    assign o_health_b   = r_health_b;
    assign o_hit_a      = r_hit_a;
    assign o_hit_b      = r_hit_b;
    assign o_game_state = r_game_state;

endmodule
`default_nettype wire

// File: tb/tb_bomb_fuse_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bomb_fuse_engine
// Description : Directed self-checking bench for bomb_fuse_engine. Expected
//               values are queued as stimulus is applied and popped when the
//               corresponding DUT output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bomb_fuse_engine;

    logic       clk = 1'b0;
    logic       reset_sw = 1'b1;
    logic       tick = 1'b0;
    logic       place_req = 1'b0;
    logic       place_owner = 1'b0;
    logic [3:0] px = 4'd0, py = 4'd0;
    logic [3:0] pa_x = 4'd0, pa_y = 4'd0, pb_x = 4'd9, pb_y = 4'd9;
    logic [3:0] qx = 4'd0, qy = 4'd0;
    logic       ack, nack, q_bomb, q_blast, hit_a, hit_b;
    logic [1:0] health_a, health_b, game_state;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;
    exp_t sb[$];

    bomb_fuse_engine dut (
        .clk          (clk),
        .reset_sw     (reset_sw),
        .i_tick_1hz   (tick),
        .i_place_req  (place_req),
        .i_place_owner(place_owner),
        .i_place_x    (px),
        .i_place_y    (py),
        .i_pa_x       (pa_x),
        .i_pa_y       (pa_y),
        .i_pb_x       (pb_x),
        .i_pb_y       (pb_y),
        .i_query_x    (qx),
        .i_query_y    (qy),
        .o_place_ack  (ack),
        .o_place_nack (nack),
        .o_q_bomb     (q_bomb),
        .o_q_blast    (q_blast),
        .o_health_a   (health_a),
        .o_health_b   (health_b),
        .o_hit_a      (hit_a),
        .o_hit_b      (hit_b),
        .o_game_state (game_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic [7:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic pop_check(input logic [7:0] obs);
        exp_t e;
        n_run++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0d required an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [1:0] eha,
                                input logic [1:0] ehb, input logic [1:0] egs);
        push({tag, "_health_a"}, 8'(eha));
        push({tag, "_health_b"}, 8'(ehb));
        push({tag, "_game_state"}, 8'(egs));
        pop_check(8'(health_a));
        pop_check(8'(health_b));
        pop_check(8'(game_state));
    endtask

    task automatic place(input logic [3:0] x, input logic [3:0] y, input logic exp_ack);
        place_req = 1'b1;
        px = x;
        py = y;
        push($sformatf("ack(%0d,%0d)", x, y), 8'(exp_ack));
        push($sformatf("nack(%0d,%0d)", x, y), 8'(!exp_ack));
        cyc();
        place_req = 1'b0;
        pop_check(8'(ack));
        pop_check(8'(nack));
    endtask

    task automatic query(input logic [3:0] x, input logic [3:0] y,
                         input logic eb, input logic ebl);
        qx = x;
        qy = y;
        push($sformatf("q_bomb(%0d,%0d)", x, y), 8'(eb));
        push($sformatf("q_blast(%0d,%0d)", x, y), 8'(ebl));
        cyc();
        pop_check(8'(q_bomb));
        pop_check(8'(q_blast));
    endtask

    // Place a bomb, run its fuse out, and check the damage edge that follows
    // the detonating tick. The freeing tick is left to the caller.
    task automatic run_bomb(input logic [3:0] x, input logic [3:0] y,
                            input logic [1:0] eha, input logic [1:0] ehb,
                            input logic ehita, input logic ehitb, input logic [1:0] egs);
        place(x, y, 1'b1);
        do_tick();
        do_tick();
        do_tick();
        push("hit_a_early", 8'd0);
        push("hit_b_early", 8'd0);
        pop_check(8'(hit_a));
        pop_check(8'(hit_b));
        cyc();
        push("hit_a", 8'(ehita));
        push("hit_b", 8'(ehitb));
        pop_check(8'(hit_a));
        pop_check(8'(hit_b));
        check_status("damage", eha, ehb, egs);
        cyc();
        push("hit_a_end", 8'd0);
        push("hit_b_end", 8'd0);
        pop_check(8'(hit_a));
        pop_check(8'(hit_b));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_status("reset", 2'd3, 2'd3, 2'd0);
        push("reset_q_bomb", 8'd0);
        push("reset_q_blast", 8'd0);
        push("reset_ack", 8'd0);
        pop_check(8'(q_bomb));
        pop_check(8'(q_blast));
        pop_check(8'(ack));
        reset_sw = 1'b0;
        cyc();

        // Single bomb lifecycle and blast shape
        place(4'd3, 4'd3, 1'b1);
        query(4'd3, 4'd3, 1'b1, 1'b0);
        do_tick();
        do_tick();
        query(4'd3, 4'd3, 1'b1, 1'b0);
        do_tick();
        query(4'd5, 4'd3, 1'b0, 1'b1);
        query(4'd3, 4'd1, 1'b0, 1'b1);
        query(4'd4, 4'd4, 1'b0, 1'b0);
        query(4'd6, 4'd3, 1'b0, 1'b0);
        query(4'd3, 4'd3, 1'b0, 1'b1);
        check_status("far_players", 2'd3, 2'd3, 2'd0);
        do_tick();
        query(4'd3, 4'd3, 1'b0, 1'b0);
        query(4'd5, 4'd3, 1'b0, 1'b0);

        // Player A hit by a detonation
        pa_x = 4'd3; pa_y = 4'd4;
        run_bomb(4'd3, 4'd3, 2'd2, 2'd3, 1'b1, 1'b0, 2'd0);
        do_tick();
        pa_x = 4'd0; pa_y = 4'd0;

        // Placement rejection cases
        place(4'd1, 4'd1, 1'b1);
        place(4'd1, 4'd1, 1'b0);
        place(4'd0, 4'd5, 1'b0);
        place(4'd5, 4'd9, 1'b0);
        place(4'd1, 4'd8, 1'b1);
        place(4'd8, 4'd1, 1'b1);
        place(4'd8, 4'd8, 1'b1);
        place(4'd5, 4'd5, 1'b0);
        query(4'd8, 4'd8, 1'b1, 1'b0);
        repeat (4) do_tick();
        query(4'd1, 4'd1, 1'b0, 1'b0);
        check_status("corners", 2'd2, 2'd3, 2'd0);

        // Placement coincident with a tick is not decremented by it
        tick = 1'b1;
        place(4'd4, 4'd4, 1'b1);
        tick = 1'b0;
        do_tick();
        do_tick();
        query(4'd4, 4'd4, 1'b1, 1'b0);
        do_tick();
        query(4'd4, 4'd4, 1'b0, 1'b1);
        do_tick();
        query(4'd4, 4'd4, 1'b0, 1'b0);

        // Neighbouring bombs: chain reaction or independent fuses
        place(4'd3, 4'd3, 1'b1);
        do_tick();
        do_tick();
        place(4'd5, 4'd3, 1'b1);
        do_tick();
        query(4'd5, 4'd3, 1'b1, 1'b1);
        do_tick();
`ifdef CHAIN_REACTION_EN
        query(4'd7, 4'd3, 1'b0, 1'b1);
        query(4'd5, 4'd3, 1'b0, 1'b1);
        do_tick();
        query(4'd7, 4'd3, 1'b0, 1'b0);
`else
        query(4'd7, 4'd3, 1'b0, 1'b0);
        query(4'd5, 4'd3, 1'b1, 1'b0);
        do_tick();
        query(4'd7, 4'd3, 1'b0, 1'b1);
`endif
        do_tick();
        query(4'd5, 4'd3, 1'b0, 1'b0);

        // Drive both players down to a draw
        pb_x = 4'd4; pb_y = 4'd3;
        run_bomb(4'd3, 4'd3, 2'd2, 2'd2, 1'b0, 1'b1, 2'd0);
        do_tick();
        pa_x = 4'd3; pa_y = 4'd4;
        run_bomb(4'd3, 4'd3, 2'd1, 2'd1, 1'b1, 1'b1, 2'd0);
        do_tick();
        run_bomb(4'd3, 4'd3, 2'd0, 2'd0, 1'b1, 1'b1, 2'd3);
        do_tick();
        do_tick();
        cyc();
        query(4'd3, 4'd3, 1'b0, 1'b1);
        check_status("game_over", 2'd0, 2'd0, 2'd3);
        place(4'd6, 4'd6, 1'b0);

        // Asynchronous mid-game reset
        #3;
        reset_sw = 1'b1;
        #1;
        check_status("async_reset", 2'd3, 2'd3, 2'd0);
        push("async_reset_q_blast", 8'd0);
        push("async_reset_nack", 8'd0);
        pop_check(8'(q_blast));
        pop_check(8'(nack));
        cyc();
        reset_sw = 1'b0;
        query(4'd3, 4'd3, 1'b0, 1'b0);
        place(4'd2, 4'd2, 1'b1);
        place(4'd2, 4'd7, 1'b1);
        place(4'd7, 4'd2, 1'b1);
        place(4'd7, 4'd7, 1'b1);
        place(4'd5, 4'd5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
